change_dispenser: RTL and testbench
===================================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port chng, input, 2 bits: change owed (00 none, 01 Rs.5, 10 Rs.10, 11 Rs.15).
REQ-004 The block SHALL have port chng_vld, input, 1 bit: one-cycle strobe qualifying chng.
REQ-005 The block SHALL have port coin_ack, input, 1 bit: mechanism confirms the requested coin was ejected.
REQ-006 The block SHALL have ports refill, refill_sel and refill_cnt, inputs, 1/1/4 bits: add refill_cnt coins to a tube (refill_sel 0 = Rs.5 tube, 1 = Rs.10 tube).
REQ-007 The block SHALL have ports coin_req and coin_sel, outputs, 1/1 bits: eject request and coin type (0 = Rs.5, 1 = Rs.10).
REQ-008 The block SHALL have ports busy, done and short, outputs, 1 bit each: transaction active, one-cycle completion pulse, and shortfall flag.
REQ-009 The block SHALL have port owed, output, 2 bits: undispensed change in Rs.5 units after a shortfall.
REQ-010 The block SHALL have ports cnt5 and cnt10, outputs, 4 bits each: tube inventories.

Function
REQ-011 The block SHALL implement the states IDLE, REQ, GAP, DONE and FAULT, with busy=1 in every state except IDLE.
REQ-012 In IDLE, chng_vld with chng=00 SHALL go to DONE; chng_vld with chng≠00 SHALL load remaining=chng and perform coin selection.
REQ-013 Coin selection SHALL choose Rs.10 if remaining≥2 and cnt10>0, else Rs.5 if cnt5>0, else go to FAULT.
REQ-014 Every output SHALL be registered, so coin_req rises in the cycle after chng_vld is sampled.
REQ-015 In REQ, coin_req=1 and coin_sel SHALL hold stable until coin_ack is sampled high.
REQ-016 On coin_ack in REQ, the selected tube SHALL decrement and remaining SHALL drop by 1 or 2; then go to DONE if remaining=0, else GAP.
REQ-017 In GAP, coin_req SHALL be 0 for exactly one cycle before the next coin selection (REQ or FAULT).
REQ-018 In DONE, done SHALL pulse for one cycle, then the block SHALL return to IDLE.
REQ-019 In FAULT, done and short SHALL pulse together for one cycle, owed=remaining, coin_req=0, then the block SHALL return to IDLE.
REQ-020 owed SHALL hold its value until the next accepted chng_vld clears it.
REQ-021 chng_vld while busy=1 SHALL be ignored.
REQ-022 coin_ack outside REQ SHALL be ignored.
REQ-023 refill SHALL be accepted in any state, with saturating add to 15.
REQ-024 A refill and a decrement of the same tube in the same cycle SHALL yield min(15, cnt-1+refill_cnt).

Reset
REQ-025 While rst=0, the block SHALL be in IDLE with coin_req, coin_sel, busy, done, short, owed, cnt5 and cnt10 all 0, regardless of state, including mid-REQ.
REQ-026 After rst deasserts, the first chng_vld SHALL be accepted on the first rising clk edge.

Configuration
REQ-027 With ACK_TIMEOUT_EN defined, a 4-bit counter SHALL count REQ cycles without coin_ack; on the 16th such cycle the block SHALL go to FAULT with owed=remaining, and no tube decrement.
REQ-028 Without ACK_TIMEOUT_EN, REQ SHALL wait for coin_ack indefinitely and no counter logic SHALL exist.

Verification
REQ-029 Refill cnt5=4, cnt10=2; chng=10 -> one coin_req with coin_sel=1, done pulse, cnt10=1, short=0.
REQ-030 cnt10=1, cnt5=4; chng=11 -> Rs.10 coin, one GAP cycle, Rs.5 coin, done; cnt10=0, cnt5=3.
REQ-031 cnt10=0, cnt5=1; chng=10 -> one Rs.5 coin, then done=1, short=1, owed=01.
REQ-032 chng=00 -> done pulse the cycle after chng_vld, coin_req never asserted.
REQ-033 Assert rst during REQ -> coin_req=0 immediately, inventories 0; a later coin_ack causes no change.
REQ-034 With ACK_TIMEOUT_EN, chng=01 and no coin_ack for 16 cycles -> short=1, owed=01, cnt5 unchanged.

Source files
------------

// File: rtl/change_dispenser.sv
// change_dispenser: pays out change in Rs.5 / Rs.10 coins from two tubes.
// A transaction starts on chng_vld in IDLE, requests one coin at a time
// (largest coin first), and ends with a done pulse. If a tube runs dry,
// it ends with a short pulse, and owed holds the unpaid amount.
// All outputs are registered.
//
// Valid/ready semantics: chng_vld is a one-cycle strobe. It is accepted
// only when busy=0. coin_req/coin_sel are held stable until coin_ack is
// sampled high. coin_ack has no effect unless coin_req is high.
//
// Optional build macro ACK_TIMEOUT_EN: abandons a coin request after 16
// cycles without coin_ack and ends the transaction as a shortfall.
module change_dispenser (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] chng,
    input  logic       chng_vld,
    input  logic       coin_ack,
    input  logic       refill,
    input  logic       refill_sel,
    input  logic [3:0] refill_cnt,
    output logic       coin_req,
    output logic       coin_sel,
    output logic       busy,
    output logic       done,
    output logic       short,
    output logic [1:0] owed,
    output logic [3:0] cnt5,
    output logic [3:0] cnt10,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_GAP   = 3'd2,
        S_DONE  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t     state, next_state;
    logic [1:0] remaining, rem_next;
    logic       sel_next;
    logic       take;
    logic [1:0] pick_rem;
    logic       pick_10, pick_ok;
    logic       coin_req_d, coin_sel_d, busy_d, done_d, short_d;
    logic [1:0] owed_d;

`ifdef ACK_TIMEOUT_EN
    logic [3:0] to_cnt, to_cnt_d;
`endif

    assign state_dbg = state;

    // Tube update: optional decrement plus optional refill, clamped at 15.
    function automatic logic [3:0] tube_next(input logic [3:0] cnt,
                                             input logic       dec,
                                             input logic       add_en,
                                             input logic [3:0] add);
        logic [4:0] sum;
        sum = {1'b0, cnt} - {4'b0, dec} + (add_en ? {1'b0, add} : 5'd0);
        return (sum > 5'd15) ? 4'd15 : sum[3:0];
    endfunction

    // Coin selection: largest coin that fits and is in stock.
    always_comb begin
        pick_rem = (state == S_IDLE) ? chng : remaining;
        pick_10  = (pick_rem >= 2'd2) && (cnt10 != 4'd0);
        pick_ok  = pick_10 || (cnt5 != 4'd0);
    end

    // State, transaction datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            remaining <= 2'd0;
            coin_req  <= 1'b0;
            coin_sel  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            short     <= 1'b0;
            owed      <= 2'd0;
        end else begin
            state     <= next_state;
            remaining <= rem_next;
            coin_req  <= coin_req_d;
            coin_sel  <= coin_sel_d;
            busy      <= busy_d;
            done      <= done_d;
            short     <= short_d;
            owed      <= owed_d;
        end
    end

    // Next-state logic, remaining-change bookkeeping, and coin choice.
    always_comb begin
        next_state = state;
        rem_next   = remaining;
        sel_next   = coin_sel;
        take       = 1'b0;
        case (state)
            S_IDLE: begin
                if (chng_vld) begin
                    rem_next = chng;
                    if (chng == 2'd0) begin
                        next_state = S_DONE;
                    end else if (pick_ok) begin
                        next_state = S_REQ;
                        sel_next   = pick_10;
                    end else begin
                        next_state = S_FAULT;
                    end
                end
            end
            S_REQ: begin
                if (coin_ack) begin
                    take       = 1'b1;
                    rem_next   = remaining - (coin_sel ? 2'd2 : 2'd1);
                    next_state = (rem_next == 2'd0) ? S_DONE : S_GAP;
                end
`ifdef ACK_TIMEOUT_EN
                else if (to_cnt == 4'd15) begin
                    next_state = S_FAULT;
                end
`endif
            end
            S_GAP: begin
                if (pick_ok) begin
                    next_state = S_REQ;
                    sel_next   = pick_10;
                end else begin
                    next_state = S_FAULT;
                end
            end
            S_DONE:  next_state = S_IDLE;
            S_FAULT: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Output values for the coming cycle, derived from the next state.
    always_comb begin
        coin_req_d = (next_state == S_REQ);
        coin_sel_d = (next_state == S_REQ) ? sel_next : 1'b0;
        busy_d     = (next_state != S_IDLE);
        done_d     = (next_state == S_DONE) || (next_state == S_FAULT);
        short_d    = (next_state == S_FAULT);
        owed_d     = owed;
        if (state == S_IDLE && chng_vld) owed_d = 2'd0;
        if (next_state == S_FAULT) owed_d = rem_next;
    end

    // Tube inventories: refills are accepted in any state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt5  <= 4'd0;
            cnt10 <= 4'd0;
        end else begin
            cnt5  <= tube_next(cnt5, take && !coin_sel, refill && !refill_sel, refill_cnt);
            cnt10 <= tube_next(cnt10, take && coin_sel, refill && refill_sel, refill_cnt);
        end
    end

`ifdef ACK_TIMEOUT_EN
    // Counts consecutive REQ cycles without coin_ack.
    always_comb begin
        to_cnt_d = (state == S_REQ && !coin_ack && next_state == S_REQ) ?
                   to_cnt + 4'd1 : 4'd0;
    end

    // Ack-timeout counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) to_cnt <= 4'd0;
        else      to_cnt <= to_cnt_d;
    end
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed transactions, with expected outcomes
// queued by the driver and checked by a monitor on each done pulse.
module tb_change_dispenser;

    localparam int W = 17;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] chng = 2'd0;
    logic       chng_vld = 1'b0;
    logic       coin_ack = 1'b0;
    logic       refill = 1'b0;
    logic       refill_sel = 1'b0;
    logic [3:0] refill_cnt = 4'd0;
    logic       coin_req, coin_sel, busy, done, short;
    logic [1:0] owed;
    logic [3:0] cnt5, cnt10;
    logic [2:0] state_dbg;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    bit ack_en = 1'b1;

    change_dispenser dut (
        .clk        (clk),
        .rst        (rst),
        .chng       (chng),
        .chng_vld   (chng_vld),
        .coin_ack   (coin_ack),
        .refill     (refill),
        .refill_sel (refill_sel),
        .refill_cnt (refill_cnt),
        .coin_req   (coin_req),
        .coin_sel   (coin_sel),
        .busy       (busy),
        .done       (done),
        .short      (short),
        .owed       (owed),
        .cnt5       (cnt5),
        .cnt10      (cnt10),
        .state_dbg  (state_dbg)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Record: {coins, coin types (first,second), gap cycles, short, owed, cnt5, cnt10}
    function automatic logic [W-1:0] mk(input logic [1:0] nc, input logic [1:0] sl,
                                        input logic [1:0] gp, input logic sh,
                                        input logic [1:0] ow, input logic [3:0] c5,
                                        input logic [3:0] c10);
        return {nc, sl, gp, sh, ow, c5, c10};
    endfunction

    // Driver tasks
    task automatic do_refill(input logic sel, input logic [3:0] n);
        @(negedge clk);
        refill = 1'b1; refill_sel = sel; refill_cnt = n;
        @(negedge clk);
        refill = 1'b0; refill_cnt = 4'd0;
    endtask

    task automatic issue_tx(input logic [1:0] c);
        @(negedge clk);
        chng = c; chng_vld = 1'b1;
        @(negedge clk);
        chng_vld = 1'b0; chng = 2'd0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (done) seen = 1'b1;
            else @(negedge clk);
        end
        check(name, {31'd0, seen}, 32'd1);
        if (seen) @(negedge clk);
    endtask

    task automatic wait_coin_req(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (coin_req) seen = 1'b1;
            else @(negedge clk);
        end
        check(name, {31'd0, seen}, 32'd1);
    endtask

    // Coin mechanism model: acks each request after 0..2 cycles
    initial begin
        forever begin
            @(negedge clk);
            if (ack_en && rst && coin_req && !coin_ack) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                coin_ack = 1'b1;
                @(negedge clk);
                coin_ack = 1'b0;
            end
        end
    end

    // Monitor: builds a record per transaction and compares on done
    initial begin
        logic [1:0] ncoins, sels, gap;
        logic       req_q, sel_q;
        logic [W-1:0] act, exp;
        ncoins = 0; sels = 0; gap = 0; req_q = 0; sel_q = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                ncoins = 0; sels = 0; gap = 0; req_q = 0;
            end else begin
                if (coin_req && !req_q) begin
                    ncoins = ncoins + 2'd1;
                    sels   = {sels[0], coin_sel};
                    sel_q  = coin_sel;
                end else if (coin_req && req_q) begin
                    check("coin_sel_stable", {31'd0, coin_sel}, {31'd0, sel_q});
                end
                if (busy && !coin_req && !done && ncoins != 2'd0) gap = gap + 2'd1;
                req_q = coin_req;
                if (done) begin
                    act = {ncoins, sels, gap, short, owed, cnt5, cnt10};
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        exp = exp_q.pop_front();
                        check("tx_record", {15'd0, act}, {15'd0, exp});
                    end
                    ncoins = 0; sels = 0; gap = 0;
                end
            end
        end
    end

    // Directed stimulus
    initial begin
        repeat (3) @(negedge clk);
        check("rst_coin_req", {31'd0, coin_req}, 32'd0);
        check("rst_coin_sel", {31'd0, coin_sel}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_short", {31'd0, short}, 32'd0);
        check("rst_owed", {30'd0, owed}, 32'd0);
        check("rst_cnt5", {28'd0, cnt5}, 32'd0);
        check("rst_cnt10", {28'd0, cnt10}, 32'd0);
        rst = 1'b1;

        do_refill(1'b0, 4'd4);
        do_refill(1'b1, 4'd2);
        check("refill_cnt5", {28'd0, cnt5}, 32'd4);
        check("refill_cnt10", {28'd0, cnt10}, 32'd2);

        // Rs.10 owed, one Rs.10 coin
        exp_q.push_back(mk(2'd1, 2'b01, 2'd0, 1'b0, 2'd0, 4'd4, 4'd1));
        issue_tx(2'b10);
        wait_done("tx1_done");

        // Rs.15 owed: Rs.10 then Rs.5, with a busy-time chng_vld ignored
        exp_q.push_back(mk(2'd2, 2'b10, 2'd1, 1'b0, 2'd0, 4'd3, 4'd0));
        issue_tx(2'b11);
        chng = 2'b01; chng_vld = 1'b1;
        @(negedge clk);
        chng_vld = 1'b0; chng = 2'd0;
        wait_done("tx2_done");

        // Rs.10 owed with no Rs.10 coins: two Rs.5 coins
        exp_q.push_back(mk(2'd2, 2'b00, 2'd1, 1'b0, 2'd0, 4'd1, 4'd0));
        issue_tx(2'b10);
        wait_done("tx3_done");

        // Rs.10 owed with one Rs.5 coin: shortfall of Rs.5
        exp_q.push_back(mk(2'd1, 2'b00, 2'd1, 1'b1, 2'd1, 4'd0, 4'd0));
        issue_tx(2'b10);
        wait_done("tx4_done");
        repeat (3) @(negedge clk);
        check("owed_hold", {30'd0, owed}, 32'd1);

        // Nothing owed: done the cycle after chng_vld, owed cleared
        exp_q.push_back(mk(2'd0, 2'b00, 2'd0, 1'b0, 2'd0, 4'd0, 4'd0));
        issue_tx(2'b00);
        check("zero_done_latency", {31'd0, done}, 32'd1);
        wait_done("tx5_done");

        // Empty tubes: immediate shortfall
        exp_q.push_back(mk(2'd0, 2'b00, 2'd0, 1'b1, 2'd1, 4'd0, 4'd0));
        issue_tx(2'b01);
        wait_done("tx6_done");

        // Saturating refills
        do_refill(1'b0, 4'd15);
        do_refill(1'b0, 4'd3);
        check("sat_cnt5", {28'd0, cnt5}, 32'd15);
        do_refill(1'b1, 4'd14);
        check("refill_cnt10_14", {28'd0, cnt10}, 32'd14);

        // Refill and decrement of the Rs.10 tube in the same cycle
        ack_en = 1'b0;
        exp_q.push_back(mk(2'd1, 2'b01, 2'd0, 1'b0, 2'd0, 4'd15, 4'd15));
        issue_tx(2'b10);
        wait_coin_req("tx7_req");
        coin_ack = 1'b1; refill = 1'b1; refill_sel = 1'b1; refill_cnt = 4'd3;
        @(negedge clk);
        coin_ack = 1'b0; refill = 1'b0; refill_cnt = 4'd0;
        wait_done("tx7_done");
        ack_en = 1'b1;

        // Rs.15 owed from full tubes
        exp_q.push_back(mk(2'd2, 2'b10, 2'd1, 1'b0, 2'd0, 4'd14, 4'd14));
        issue_tx(2'b11);
        wait_done("tx8_done");

        // coin_ack in IDLE has no effect
        ack_en = 1'b0;
        @(negedge clk); coin_ack = 1'b1;
        @(negedge clk); coin_ack = 1'b0;
        @(negedge clk);
        check("idle_ack_cnt5", {28'd0, cnt5}, 32'd14);
        check("idle_ack_cnt10", {28'd0, cnt10}, 32'd14);
        check("idle_ack_state", {29'd0, state_dbg}, 32'd0);

        // Reset asserted mid-REQ
        do_refill(1'b0, 4'd2);
        check("sat_cnt5_again", {28'd0, cnt5}, 32'd15);
        issue_tx(2'b01);
        check("pre_rst_coin_req", {31'd0, coin_req}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_coin_req", {31'd0, coin_req}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_cnt5", {28'd0, cnt5}, 32'd0);
        check("mid_rst_cnt10", {28'd0, cnt10}, 32'd0);
        check("mid_rst_state", {29'd0, state_dbg}, 32'd0);
        @(negedge clk);
        rst = 1'b1; coin_ack = 1'b1;
        @(negedge clk);
        coin_ack = 1'b0;
        @(negedge clk);
        check("late_ack_cnt5", {28'd0, cnt5}, 32'd0);
        check("late_ack_coin_req", {31'd0, coin_req}, 32'd0);
        check("late_ack_busy", {31'd0, busy}, 32'd0);

        // First chng_vld accepted on the first edge after reset release
        rst = 1'b0;
        @(negedge clk);
        exp_q.push_back(mk(2'd0, 2'b00, 2'd0, 1'b0, 2'd0, 4'd0, 4'd0));
        rst = 1'b1; chng = 2'b00; chng_vld = 1'b1;
        @(negedge clk);
        chng_vld = 1'b0;
        check("first_edge_accept", {31'd0, done}, 32'd1);
        wait_done("tx9_done");

`ifdef ACK_TIMEOUT_EN
        // No coin_ack: request abandoned after 16 cycles
        do_refill(1'b0, 4'd2);
        exp_q.push_back(mk(2'd1, 2'b00, 2'd0, 1'b1, 2'd1, 4'd2, 4'd0));
        issue_tx(2'b01);
        wait_done("timeout_done");
`endif

        repeat (5) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
